// File: rtl/spart_fifo.sv
// spart_fifo: full-duplex UART with 16x oversampled RX, RX/TX FIFOs and a programmable baud divisor.
// Define SPART_PARITY_EN to append an even-parity bit to every frame (TX insert, RX check).
module spart_fifo_buf #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] head,
  output logic         empty,
  output logic         full
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wp;
  logic [AW:0]  rp;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) wp <= wp + PTR_ONE;
      if (pop)  rp <= rp + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wp[AW-1:0]] <= wdata;
  end

  assign head  = mem[rp[AW-1:0]];
  assign empty = (wp == rp);
  assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
endmodule

module spart_fifo #(
  parameter int          DATA_BITS  = 8,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] DIV_RESET  = 16'd324
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       iocs,
  input  logic       iorw,
  input  logic [1:0] ioaddr,
  inout  wire  [7:0] databus,
  output logic       rda,
  output logic       tbr,
  output logic       txd,
  input  logic       rxd
);
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef SPART_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  logic rd, wr;
  logic [7:0] rdata;
  logic [15:0] div, baud_cnt;
  logic tick;
  logic rx_m, rx_s, rx_prev;
  state_t rx_state, tx_state;
  logic [3:0] rx_tcnt, tx_tcnt;
  logic [2:0] rx_bcnt, tx_bcnt;
  logic [DATA_BITS-1:0] rx_shift, tx_shift, rx_head, tx_head;
  logic rx_push, fe_set, pe_set;
  logic rx_empty, rx_full, tx_empty, tx_full;
  logic rx_pop, rx_push_ok, tx_pop, tx_push, tx_idle;
  logic overrun, frame_err, parity_err, err_clr;

  assign rd      = iocs & iorw;
  assign wr      = iocs & ~iorw;
  assign err_clr = wr && (ioaddr == 2'b01);
  assign tick    = (baud_cnt == 16'd0);

  // Divisor writes restart the down-counter so the new rate applies immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div      <= DIV_RESET;
      baud_cnt <= DIV_RESET;
    end else if (wr && ioaddr == 2'b10) begin
      div[7:0] <= databus;
      baud_cnt <= {div[15:8], databus};
    end else if (wr && ioaddr == 2'b11) begin
      div[15:8] <= databus;
      baud_cnt  <= {databus, div[7:0]};
    end else if (tick) begin
      baud_cnt <= div;
    end else begin
      baud_cnt <= baud_cnt - 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_m    <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_m    <= rxd;
      rx_s    <= rx_m;
      rx_prev <= rx_s;
    end
  end

  // Receiver: start validated at mid-bit (8 ticks), then every bit sampled 16 ticks apart.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_state <= S_IDLE;
      rx_tcnt  <= '0;
      rx_bcnt  <= '0;
      rx_shift <= '0;
      rx_push  <= 1'b0;
      fe_set   <= 1'b0;
      pe_set   <= 1'b0;
    end else begin
      rx_push <= 1'b0;
      fe_set  <= 1'b0;
      pe_set  <= 1'b0;
      case (rx_state)
        S_IDLE: if (rx_prev && !rx_s) begin
          rx_state <= S_START;
          rx_tcnt  <= '0;
        end
        S_START: if (tick) begin
          if (rx_tcnt == 4'd7) begin
            rx_tcnt  <= '0;
            rx_bcnt  <= '0;
            rx_state <= rx_s ? S_IDLE : S_DATA;
          end else begin
            rx_tcnt <= rx_tcnt + 4'd1;
          end
        end
        S_DATA: if (tick) begin
          rx_tcnt <= rx_tcnt + 4'd1;
          if (rx_tcnt == 4'd15) begin
            rx_shift <= {rx_s, rx_shift[DATA_BITS-1:1]};
            rx_bcnt  <= rx_bcnt + 3'd1;
`ifdef SPART_PARITY_EN
            if (rx_bcnt == LAST_BIT) rx_state <= S_PARITY;
`else
            if (rx_bcnt == LAST_BIT) rx_state <= S_STOP;
`endif
          end
        end
`ifdef SPART_PARITY_EN
        S_PARITY: if (tick) begin
          rx_tcnt <= rx_tcnt + 4'd1;
          if (rx_tcnt == 4'd15) begin
            pe_set   <= (rx_s != ^rx_shift);
            rx_state <= S_STOP;
          end
        end
`endif
        S_STOP: if (tick) begin
          rx_tcnt <= rx_tcnt + 4'd1;
          if (rx_tcnt == 4'd15) begin
            rx_push  <= rx_s;
            fe_set   <= ~rx_s;
            rx_state <= S_IDLE;
          end
        end
        default: rx_state <= S_IDLE;
      endcase
    end
  end

  // A same-cycle pop frees a slot, so a push into a full FIFO still lands.
  assign rx_pop     = rd && (ioaddr == 2'b00) && !rx_empty;
  assign rx_push_ok = rx_push && (!rx_full || rx_pop);

  spart_fifo_buf #(.W(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .rst(rst), .push(rx_push_ok), .pop(rx_pop), .wdata(rx_shift),
    .head(rx_head), .empty(rx_empty), .full(rx_full)
  );

  assign tx_pop  = tick && !tx_empty &&
                   ((tx_state == S_IDLE) || (tx_state == S_STOP && tx_tcnt == 4'd15));
  assign tx_push = wr && (ioaddr == 2'b00) && (!tx_full || tx_pop);

  spart_fifo_buf #(.W(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .rst(rst), .push(tx_push), .pop(tx_pop), .wdata(databus[DATA_BITS-1:0]),
    .head(tx_head), .empty(tx_empty), .full(tx_full)
  );

`ifdef SPART_PARITY_EN
  logic tx_par;
`endif

  // Transmitter: loading from the FIFO at the end of a stop bit gives gap-free frames.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state <= S_IDLE;
      txd      <= 1'b1;
      tx_tcnt  <= '0;
      tx_bcnt  <= '0;
      tx_shift <= '0;
`ifdef SPART_PARITY_EN
      tx_par   <= 1'b0;
`endif
    end else if (tx_pop) begin
      tx_state <= S_START;
      txd      <= 1'b0;
      tx_tcnt  <= '0;
      tx_shift <= tx_head;
`ifdef SPART_PARITY_EN
      tx_par   <= ^tx_head;
`endif
    end else begin
      if (tick && tx_state != S_IDLE) tx_tcnt <= tx_tcnt + 4'd1;
      case (tx_state)
        S_IDLE: txd <= 1'b1;
        S_START: if (tick && tx_tcnt == 4'd15) begin
          tx_state <= S_DATA;
          txd      <= tx_shift[0];
          tx_bcnt  <= '0;
        end
        S_DATA: if (tick && tx_tcnt == 4'd15) begin
          if (tx_bcnt == LAST_BIT) begin
`ifdef SPART_PARITY_EN
            tx_state <= S_PARITY;
            txd      <= tx_par;
`else
            tx_state <= S_STOP;
            txd      <= 1'b1;
`endif
          end else begin
            tx_bcnt  <= tx_bcnt + 3'd1;
            tx_shift <= tx_shift >> 1;
            txd      <= tx_shift[1];
          end
        end
`ifdef SPART_PARITY_EN
        S_PARITY: if (tick && tx_tcnt == 4'd15) begin
          tx_state <= S_STOP;
          txd      <= 1'b1;
        end
`endif
        S_STOP: if (tick && tx_tcnt == 4'd15) begin
          tx_state <= S_IDLE;
          txd      <= 1'b1;
        end
        default: tx_state <= S_IDLE;
      endcase
    end
  end

  // Sticky errors: a set in the same cycle as a clear wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      overrun   <= (rx_push && rx_full && !rx_pop) ? 1'b1 : (err_clr ? 1'b0 : overrun);
      frame_err <= fe_set ? 1'b1 : (err_clr ? 1'b0 : frame_err);
    end
  end

`ifdef SPART_PARITY_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) parity_err <= 1'b0;
    else      parity_err <= pe_set ? 1'b1 : (err_clr ? 1'b0 : parity_err);
  end
`else
  assign parity_err = 1'b0;
  logic unused_pe;
  assign unused_pe = pe_set;
`endif

  assign rda     = !rx_empty;
  assign tbr     = !tx_full;
  assign tx_idle = tx_empty && (tx_state == S_IDLE);

  always_comb begin
    rdata = 8'h00;
    case (ioaddr)
      2'b00: rdata = rx_empty ? 8'h00 : 8'(rx_head);
      2'b01: rdata = {2'b00, parity_err, frame_err, overrun, tx_idle, tbr, rda};
      2'b10: rdata = div[7:0];
      2'b11: rdata = div[15:8];
      default: rdata = 8'h00;
    endcase
  end

  assign databus = rd ? rdata : 8'hzz;
endmodule

// File: tb/tb_spart_fifo.sv
// Self-checking bench for spart_fifo: register map, TX waveform, loopback, overrun, framing and glitch rejection.
// Build with +define+SPART_PARITY_EN to also cover the parity frames.
`timescale 1ns/1ps
module tb_spart_fifo;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       iocs = 1'b0;
  logic       iorw = 1'b0;
  logic [1:0] ioaddr = 2'b00;
  wire  [7:0] databus;
  logic       rda, tbr, txd, rxd;
  logic       drv_en = 1'b0;
  logic [7:0] drv_data = 8'h00;
  logic       loop_en = 1'b0;
  logic       rx_drv = 1'b1;
  logic [7:0] exp_q[$];
  int         n_cmp = 0;
  int         n_err = 0;

  assign databus = drv_en ? drv_data : 8'hzz;
  assign rxd     = loop_en ? txd : rx_drv;

  always #5 clk = ~clk;

  spart_fifo dut (
    .clk(clk), .rst(rst), .iocs(iocs), .iorw(iorw), .ioaddr(ioaddr),
    .databus(databus), .rda(rda), .tbr(tbr), .txd(txd), .rxd(rxd)
  );

  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    iocs = 1'b1; iorw = 1'b0; ioaddr = a; drv_data = d; drv_en = 1'b1;
    @(posedge clk); #1;
    iocs = 1'b0; drv_en = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
    @(negedge clk);
    iocs = 1'b1; iorw = 1'b1; ioaddr = a;
    #1 d = databus;
    @(posedge clk); #1;
    iocs = 1'b0; iorw = 1'b0;
  endtask

  // One serial frame on rxd at 64 clocks per bit (divisor 3).
  task automatic drive_frame(input logic [7:0] d, input logic stop_bit, input logic par_bit);
    rx_drv = 1'b0;
    repeat (64) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_drv = d[i];
      repeat (64) @(negedge clk);
    end
`ifdef SPART_PARITY_EN
    rx_drv = par_bit;
    repeat (64) @(negedge clk);
`endif
    rx_drv = stop_bit;
    repeat (64) @(negedge clk);
    rx_drv = 1'b1;
    repeat (32) @(negedge clk);
  endtask

  task automatic wait_tx_idle(input int budget);
    logic [7:0] s;
    int n = 0;
    s = 8'h00;
    while (s[2] !== 1'b1 && n < budget) begin
      bus_read(2'b01, s);
      n++;
    end
    n_cmp++;
    if (s[2] !== 1'b1) begin
      $display("FAIL tx_idle_timeout: got status %h required bit2 set", s);
      n_err++;
    end
  endtask

  task automatic test_reset();
    logic [7:0] v;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (txd !== 1'b1) begin $display("FAIL reset_txd: got %b required 1", txd); n_err++; end
    n_cmp++; if (rda !== 1'b0) begin $display("FAIL reset_rda: got %b required 0", rda); n_err++; end
    n_cmp++; if (tbr !== 1'b1) begin $display("FAIL reset_tbr: got %b required 1", tbr); n_err++; end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    bus_read(2'b01, v);
    n_cmp++; if (v !== 8'h06) begin $display("FAIL reset_status: got %h required 06", v); n_err++; end
    bus_read(2'b10, v);
    n_cmp++; if (v !== 8'h44) begin $display("FAIL reset_div_lo: got %h required 44", v); n_err++; end
    bus_read(2'b11, v);
    n_cmp++; if (v !== 8'h01) begin $display("FAIL reset_div_hi: got %h required 01", v); n_err++; end
    bus_read(2'b00, v);
    n_cmp++; if (v !== 8'h00) begin $display("FAIL reset_rx_empty: got %h required 00", v); n_err++; end
  endtask

  // Divisor 0: one tick per clock, so each bit lasts 16 clocks. Needs d[0]=1 to time the start bit.
  task automatic test_tx_bits(input logic [7:0] d);
    logic [10:0] bits;
    int nbits;
    int cnt;
    logic [7:0] v;
    bits = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = d[i];
`ifdef SPART_PARITY_EN
    bits[9] = ^d;
    nbits = 11;
`else
    nbits = 10;
`endif
    bus_write(2'b00, d);
    cnt = 0;
    while (txd !== 1'b0 && cnt < 200) begin @(negedge clk); cnt++; end
    n_cmp++;
    if (txd !== 1'b0) begin
      $display("FAIL tx_start_timeout: got txd %b required 0", txd);
      n_err++;
    end else begin
      cnt = 0;
      while (txd === 1'b0 && cnt < 40) begin @(negedge clk); cnt++; end
      n_cmp++; if (cnt != 16) begin $display("FAIL tx_start_len: got %0d required 16 clocks", cnt); n_err++; end
      repeat (8) @(negedge clk);
      for (int k = 1; k < nbits; k++) begin
        n_cmp++;
        if (txd !== bits[k]) begin
          $display("FAIL tx_bit%0d: got %b required %b (data %h)", k, txd, bits[k], d);
          n_err++;
        end
        repeat (16) @(negedge clk);
      end
    end
    wait_tx_idle(100);
    bus_read(2'b01, v);
    n_cmp++; if (v !== 8'h06) begin $display("FAIL tx_done_status: got %h required 06", v); n_err++; end
  endtask

  task automatic test_loopback();
    logic [7:0] v, e;
    logic [7:0] pat [3];
    pat[0] = 8'h3C; pat[1] = 8'h7E; pat[2] = 8'h81;
    bus_write(2'b10, 8'h03);
    bus_write(2'b11, 8'h00);
    loop_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus_write(2'b00, pat[i]);
      exp_q.push_back(pat[i]);
    end
    wait_tx_idle(5000);
    repeat (100) @(negedge clk);
    n_cmp++; if (rda !== 1'b1) begin $display("FAIL loop_rda: got %b required 1", rda); n_err++; end
    for (int i = 0; i < 3; i++) begin
      bus_read(2'b00, v);
      e = exp_q.pop_front();
      n_cmp++; if (v !== e) begin $display("FAIL loop_read%0d: got %h required %h", i, v, e); n_err++; end
    end
    bus_read(2'b00, v);
    n_cmp++; if (v !== 8'h00) begin $display("FAIL loop_empty_read: got %h required 00", v); n_err++; end
    n_cmp++; if (rda !== 1'b0) begin $display("FAIL loop_rda_low: got %b required 0", rda); n_err++; end
    loop_en = 1'b0;
    rx_drv = 1'b1;
  endtask

  task automatic test_overrun();
    logic [7:0] v, e, d;
    for (int i = 0; i < 5; i++) begin
      d = 8'h11 * 8'(i + 1);
      drive_frame(d, 1'b1, ^d);
      if (i < 4) exp_q.push_back(d);
    end
    bus_read(2'b01, v);
    n_cmp++; if (v !== 8'h0F) begin $display("FAIL ovr_status: got %h required 0F", v); n_err++; end
    for (int i = 0; i < 4; i++) begin
      bus_read(2'b00, v);
      e = exp_q.pop_front();
      n_cmp++; if (v !== e) begin $display("FAIL ovr_read%0d: got %h required %h", i, v, e); n_err++; end
    end
    bus_read(2'b01, v);
    n_cmp++; if (v !== 8'h0E) begin $display("FAIL ovr_sticky: got %h required 0E", v); n_err++; end
    bus_write(2'b01, 8'hFF);
    bus_read(2'b01, v);
    n_cmp++; if (v !== 8'h06) begin $display("FAIL ovr_clear: got %h required 06", v); n_err++; end
  endtask

  task automatic test_frame_err();
    logic [7:0] v;
    drive_frame(8'h55, 1'b0, 1'b0);
    n_cmp++; if (rda !== 1'b0) begin $display("FAIL ferr_rda: got %b required 0", rda); n_err++; end
    bus_read(2'b01, v);
    n_cmp++; if (v !== 8'h16) begin $display("FAIL ferr_status: got %h required 16", v); n_err++; end
    bus_write(2'b01, 8'h00);
    bus_read(2'b01, v);
    n_cmp++; if (v !== 8'h06) begin $display("FAIL ferr_clear: got %h required 06", v); n_err++; end
  endtask

  task automatic test_glitch();
    logic [7:0] v;
    rx_drv = 1'b0;
    repeat (12) @(negedge clk);
    rx_drv = 1'b1;
    repeat (300) @(negedge clk);
    n_cmp++; if (rda !== 1'b0) begin $display("FAIL glitch_rda: got %b required 0", rda); n_err++; end
    bus_read(2'b01, v);
    n_cmp++; if (v !== 8'h06) begin $display("FAIL glitch_status: got %h required 06", v); n_err++; end
  endtask

`ifdef SPART_PARITY_EN
  task automatic test_parity();
    logic [7:0] v;
    bus_write(2'b10, 8'h00);
    test_tx_bits(8'h03);
    bus_write(2'b10, 8'h03);
    exp_q.push_back(8'h01);
    drive_frame(8'h01, 1'b1, 1'b0);
    bus_read(2'b01, v);
    n_cmp++; if (v !== 8'h27) begin $display("FAIL par_status: got %h required 27", v); n_err++; end
    bus_read(2'b00, v);
    n_cmp++; if (v !== exp_q[0]) begin $display("FAIL par_data: got %h required %h", v, exp_q[0]); n_err++; end
    void'(exp_q.pop_front());
    bus_write(2'b01, 8'h00);
    bus_read(2'b01, v);
    n_cmp++; if (v !== 8'h06) begin $display("FAIL par_clear: got %h required 06", v); n_err++; end
  endtask
`endif

  initial begin
    test_reset();
    bus_write(2'b10, 8'h00);
    bus_write(2'b11, 8'h00);
    test_tx_bits(8'hA5);
    test_loopback();
    test_overrun();
    test_frame_err();
    test_glitch();
`ifdef SPART_PARITY_EN
    test_parity();
`endif
    n_cmp++;
    if (exp_q.size() != 0) begin
      $display("FAIL scoreboard_leftover: got %0d entries required 0", exp_q.size());
      n_err++;
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
